// File: rtl/shift_sequencer.sv
// Multi-pass command sequencer for an external combinational barrel_shifter.
// Define SHIFT_SEQ_ROTATE_EN to build rotates (ROL/ROR) from two opposite passes.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [AMT_W-1:0]           in_amount,
  input  logic [1:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       busy,
  output logic [WIDTH-1:0]           bs_data_in,
  output logic [$clog2(WIDTH)-1:0]   bs_shift_amount,
  output logic                       bs_dir,
  input  logic [WIDTH-1:0]           bs_data_out
);
  localparam int SW   = $clog2(WIDTH);
  localparam int MAXP = WIDTH - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ROT2  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  generate
    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("shift_sequencer: WIDTH must be a power of two >= 4");
    end
    if (AMT_W < SW) begin : g_bad_amt
      $error("shift_sequencer: AMT_W must be >= clog2(WIDTH)");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] remaining;
  logic             dir_q;
  logic             rot_q;
  logic             ld_rot;
  logic [SW-1:0]    pass;
  logic [SW-1:0]    amt_lo;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic [WIDTH-1:0] acc;
  logic [SW-1:0]    rot_amt;
  assign ld_rot  = in_op[1];
  // WIDTH - r computed modulo 2^SW; r is never 0 in ROT2 so this is in 1..MAXP
  assign rot_amt = SW'(0) - remaining[SW-1:0];
`else
  logic unused_op;
  assign unused_op = in_op[1];
  assign ld_rot    = 1'b0;
  assign rot_q     = 1'b0;
`endif

  assign amt_lo = in_amount[SW-1:0];

  always_comb begin
    if (remaining > AMT_W'(MAXP)) pass = SW'(MAXP);
    else                          pass = remaining[SW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
      dir_q     <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q     <= 1'b0;
      acc       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            dir_q <= in_op[0];
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q <= in_op[1];
`endif
            if (ld_rot) begin
              remaining <= AMT_W'(amt_lo);
              state     <= (amt_lo == '0) ? DONE : SHIFT;
            end else begin
              remaining <= in_amount;
              state     <= (in_amount == '0) ? DONE : SHIFT;
            end
          end
        end
        SHIFT: begin
          if (rot_q) begin
`ifdef SHIFT_SEQ_ROTATE_EN
            // first half of the rotate; operand stays in work for ROT2
            acc   <= bs_data_out;
            state <= ROT2;
`else
            state <= IDLE;
`endif
          end else begin
            work      <= bs_data_out;
            remaining <= remaining - AMT_W'(pass);
            if (remaining == AMT_W'(pass)) state <= DONE;
          end
        end
        ROT2: begin
`ifdef SHIFT_SEQ_ROTATE_EN
          work  <= acc | bs_data_out;
          state <= DONE;
`else
          state <= IDLE;
`endif
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = work;

  always_comb begin
    bs_data_in      = '0;
    bs_shift_amount = '0;
    bs_dir          = 1'b0;
    if (state == SHIFT) begin
      bs_data_in      = work;
      bs_shift_amount = pass;
      bs_dir          = dir_q;
    end
`ifdef SHIFT_SEQ_ROTATE_EN
    else if (state == ROT2) begin
      bs_data_in      = work;
      bs_shift_amount = rot_amt;
      bs_dir          = ~dir_q;
    end
`endif
  end
endmodule
